// File: rtl/irda_dma_arbiter.sv
// Round-robin sharing of the single external DMA channel between TX-fifo refill
// and RX-fifo drain requests, with per-burst sizing and a stall timeout.
module irda_dma_arbiter #(
  parameter int BURST = 8,
  parameter int TO_W  = 8
) (
  input  logic       clk,
  input  logic       wb_rst_n_i,
  input  logic       use_dma,
  input  logic       dma_req_t_i,
  input  logic       dma_req_r_i,
  output logic       dma_ack_t_o,
  output logic       dma_ack_r_o,
  input  logic [4:0] txfifo_count,
  input  logic [4:0] rxfifo_count,
  output logic       dma_req_o,
  output logic       dma_dir_o,
  input  logic       dma_ack_i,
  output logic       txfifo_push_o,
  output logic       rxfifo_pop_o,
  output logic       busy_o,
  output logic       dma_err_o,
  input  logic       err_clr_i,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE, S_COOL} state_t;

  localparam logic [4:0]      BURST_L = 5'(BURST);
  localparam logic [TO_W-1:0] TO_LAST = ~TO_W'(1);

  state_t          state_q, state_d;
  logic [4:0]      remaining_q;
  logic [TO_W-1:0] to_cnt_q;
  logic            req_q, dir_q, last_rx_q, err_q;

  logic [4:0] tx_room, tx_len, rx_len;
  logic       tx_elig, rx_elig, win, grant_rx, to_hit, err_set;

  assign tx_room  = 5'd16 - txfifo_count;
  assign tx_len   = (tx_room > BURST_L) ? BURST_L : tx_room;
  assign rx_len   = (rxfifo_count > BURST_L) ? BURST_L : rxfifo_count;
  assign tx_elig  = dma_req_t_i && (tx_len != 5'd0);
  assign rx_elig  = dma_req_r_i && (rx_len != 5'd0);
  assign win      = tx_elig || rx_elig;
  // On a tie the side not served by the last completed burst goes next.
  assign grant_rx = rx_elig && (!tx_elig || !last_rx_q);
  // Fires on the 2^TO_W-1'th consecutive XFER cycle without a word ack.
  assign to_hit   = (to_cnt_q == TO_LAST) && !dma_ack_i;
  assign err_set  = use_dma && (state_q == S_XFER) && to_hit;

  always_ff @(posedge clk or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) state_q <= S_IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!use_dma) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (win) state_d = S_XFER;
        S_XFER: begin
          if (dma_ack_i && remaining_q == 5'd1) state_d = S_DONE;
          else if (to_hit)                     state_d = S_COOL;
        end
        S_DONE:  state_d = S_COOL;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      remaining_q <= '0;
      to_cnt_q    <= '0;
      req_q       <= 1'b0;
      dir_q       <= 1'b0;
      last_rx_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (!use_dma) begin
        req_q       <= 1'b0;
        remaining_q <= '0;
        to_cnt_q    <= '0;
      end else begin
        case (state_q)
          S_IDLE: if (win) begin
            remaining_q <= grant_rx ? rx_len : tx_len;
            dir_q       <= grant_rx;
            req_q       <= 1'b1;
            to_cnt_q    <= '0;
          end
          S_XFER: begin
            if (dma_ack_i) begin
              remaining_q <= remaining_q - 5'd1;
              to_cnt_q    <= '0;
              if (remaining_q == 5'd1) req_q <= 1'b0;
            end else if (to_hit) begin
              req_q       <= 1'b0;
              remaining_q <= '0;
              to_cnt_q    <= '0;
            end else begin
              to_cnt_q <= to_cnt_q + 1'b1;
            end
          end
          S_DONE:  last_rx_q <= dir_q;
          default: ;
        endcase
      end
      if (err_set)        err_q <= 1'b1;
      else if (err_clr_i) err_q <= 1'b0;
    end
  end

  // Channel handshake: every cycle with dma_req_o=1 and dma_ack_i=1 moves one
  // word; dma_dir_o is held stable for as long as dma_req_o is high.
  always_comb begin
    txfifo_push_o = 1'b0;
    rxfifo_pop_o  = 1'b0;
    dma_ack_t_o   = 1'b0;
    dma_ack_r_o   = 1'b0;
    if (state_q == S_XFER && dma_ack_i) begin
      txfifo_push_o = !dir_q;
      rxfifo_pop_o  = dir_q;
    end
    if (state_q == S_DONE) begin
      dma_ack_t_o = !dir_q;
      dma_ack_r_o = dir_q;
    end
  end

  assign dma_req_o   = req_q;
  assign dma_dir_o   = dir_q;
  assign busy_o      = (state_q != S_IDLE);
  assign dma_err_o   = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_irda_dma_arbiter.sv
// Directed bench for irda_dma_arbiter: burst sizing, round-robin ties,
// timeout abort, DMA disable and asynchronous reset.
module tb_irda_dma_arbiter;

  logic       clk = 1'b0;
  logic       wb_rst_n_i, use_dma, dma_req_t_i, dma_req_r_i;
  logic       dma_ack_t_o, dma_ack_r_o;
  logic [4:0] txfifo_count, rxfifo_count;
  logic       dma_req_o, dma_dir_o, dma_ack_i;
  logic       txfifo_push_o, rxfifo_pop_o, busy_o, dma_err_o, err_clr_i;
  logic [1:0] dbg_state_o;

  int tests = 0;
  int fails = 0;
  int push_cnt = 0;

  irda_dma_arbiter #(.BURST(8), .TO_W(8)) dut (
    .clk(clk), .wb_rst_n_i(wb_rst_n_i), .use_dma(use_dma),
    .dma_req_t_i(dma_req_t_i), .dma_req_r_i(dma_req_r_i),
    .dma_ack_t_o(dma_ack_t_o), .dma_ack_r_o(dma_ack_r_o),
    .txfifo_count(txfifo_count), .rxfifo_count(rxfifo_count),
    .dma_req_o(dma_req_o), .dma_dir_o(dma_dir_o), .dma_ack_i(dma_ack_i),
    .txfifo_push_o(txfifo_push_o), .rxfifo_pop_o(rxfifo_pop_o),
    .busy_o(busy_o), .dma_err_o(dma_err_o), .err_clr_i(err_clr_i),
    .dbg_state_o(dbg_state_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (txfifo_push_o) push_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One word ack per cycle for n cycles; checks the strobe routing each word.
  task automatic ack_words(input int n, input logic exp_dir);
    for (int i = 0; i < n; i++) begin
      dma_ack_i = 1'b1;
      #1;
      chk("push_strobe", 32'(txfifo_push_o), 32'(!exp_dir));
      chk("pop_strobe", 32'(rxfifo_pop_o), 32'(exp_dir));
      chk("dir_stable", 32'(dma_dir_o), 32'(exp_dir));
      tick();
    end
    dma_ack_i = 1'b0;
  endtask

  initial begin
    wb_rst_n_i = 1'b0; use_dma = 1'b1; dma_req_t_i = 1'b0; dma_req_r_i = 1'b0;
    txfifo_count = 5'd0; rxfifo_count = 5'd0; dma_ack_i = 1'b0; err_clr_i = 1'b0;
    #1;
    chk("rst_req", 32'(dma_req_o), 32'd0);
    chk("rst_dir", 32'(dma_dir_o), 32'd0);
    chk("rst_ack_t", 32'(dma_ack_t_o), 32'd0);
    chk("rst_ack_r", 32'(dma_ack_r_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_err", 32'(dma_err_o), 32'd0);
    chk("rst_push", 32'(txfifo_push_o), 32'd0);
    chk("rst_pop", 32'(rxfifo_pop_o), 32'd0);
    tick(); tick();
    wb_rst_n_i = 1'b1;
    tick();

    // TX only, fill 4 -> 8-word burst; fill change mid-burst is ignored.
    txfifo_count = 5'd4; dma_req_t_i = 1'b1; push_cnt = 0;
    tick();
    chk("t1_grant_req", 32'(dma_req_o), 32'd1);
    chk("t1_grant_dir", 32'(dma_dir_o), 32'd0);
    chk("t1_busy", 32'(busy_o), 32'd1);
    dma_req_t_i = 1'b0;
    ack_words(4, 1'b0);
    txfifo_count = 5'd15;
    ack_words(3, 1'b0);
    chk("t1_no_early_ack", 32'(dma_ack_t_o), 32'd0);
    chk("t1_req_held", 32'(dma_req_o), 32'd1);
    ack_words(1, 1'b0);
    chk("t1_done_ack_t", 32'(dma_ack_t_o), 32'd1);
    chk("t1_done_ack_r", 32'(dma_ack_r_o), 32'd0);
    chk("t1_done_req", 32'(dma_req_o), 32'd0);
    chk("t1_push_cnt", 32'(push_cnt), 32'd8);
    tick();
    chk("t1_cool_ack_t", 32'(dma_ack_t_o), 32'd0);
    chk("t1_cool_busy", 32'(busy_o), 32'd1);
    tick();
    chk("t1_idle_busy", 32'(busy_o), 32'd0);

    // TX only, fill 12 -> 4-word burst; fill 16 -> never granted.
    txfifo_count = 5'd12; dma_req_t_i = 1'b1;
    tick();
    chk("t2_grant", 32'(dma_req_o), 32'd1);
    dma_req_t_i = 1'b0;
    ack_words(3, 1'b0);
    chk("t2_not_done", 32'(dma_ack_t_o), 32'd0);
    ack_words(1, 1'b0);
    chk("t2_done_ack_t", 32'(dma_ack_t_o), 32'd1);
    tick(); tick();
    txfifo_count = 5'd16; dma_req_t_i = 1'b1;
    tick(); tick(); tick();
    chk("t2_full_no_req", 32'(dma_req_o), 32'd0);
    chk("t2_full_idle", 32'(busy_o), 32'd0);
    dma_req_t_i = 1'b0;

    // Ties: RX (3 words), then TX (2 words), then RX again.
    txfifo_count = 5'd14; rxfifo_count = 5'd3;
    dma_req_t_i = 1'b1; dma_req_r_i = 1'b1;
    tick();
    chk("tie1_dir_rx", 32'(dma_dir_o), 32'd1);
    ack_words(3, 1'b1);
    chk("tie1_ack_r", 32'(dma_ack_r_o), 32'd1);
    chk("tie1_ack_t", 32'(dma_ack_t_o), 32'd0);
    tick();
    chk("tie1_cool_req", 32'(dma_req_o), 32'd0);
    tick();
    chk("tie1_idle", 32'(busy_o), 32'd0);
    tick();
    chk("tie2_req", 32'(dma_req_o), 32'd1);
    chk("tie2_dir_tx", 32'(dma_dir_o), 32'd0);
    ack_words(2, 1'b0);
    chk("tie2_ack_t", 32'(dma_ack_t_o), 32'd1);
    tick(); tick(); tick();
    chk("tie3_dir_rx", 32'(dma_dir_o), 32'd1);
    dma_req_t_i = 1'b0; dma_req_r_i = 1'b0;
    ack_words(3, 1'b1);
    chk("tie3_ack_r", 32'(dma_ack_r_o), 32'd1);
    tick(); tick();

    // RX burst stalls for 255 cycles -> timeout, error, retry.
    rxfifo_count = 5'd16; dma_req_r_i = 1'b1;
    tick();
    chk("to_grant_dir", 32'(dma_dir_o), 32'd1);
    chk("to_err_pre", 32'(dma_err_o), 32'd0);
    for (int i = 0; i < 254; i++) tick();
    chk("to_still_xfer", 32'(dma_req_o), 32'd1);
    chk("to_no_err_yet", 32'(dma_err_o), 32'd0);
    tick();
    chk("to_cool_req", 32'(dma_req_o), 32'd0);
    chk("to_err_set", 32'(dma_err_o), 32'd1);
    chk("to_no_ack_r", 32'(dma_ack_r_o), 32'd0);
    chk("to_cool_busy", 32'(busy_o), 32'd1);
    tick();
    chk("to_idle_no_ack", 32'(dma_ack_r_o), 32'd0);
    chk("to_idle_busy", 32'(busy_o), 32'd0);
    tick();
    chk("to_regrant", 32'(dma_req_o), 32'd1);
    chk("to_err_sticky", 32'(dma_err_o), 32'd1);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    chk("to_err_clr", 32'(dma_err_o), 32'd0);

    // DMA disabled after 3 of 8 words.
    ack_words(3, 1'b1);
    dma_req_r_i = 1'b0; use_dma = 1'b0;
    tick();
    chk("off_req", 32'(dma_req_o), 32'd0);
    chk("off_idle", 32'(busy_o), 32'd0);
    chk("off_no_ack_r", 32'(dma_ack_r_o), 32'd0);
    dma_ack_i = 1'b1;
    #1;
    chk("off_stray_pop", 32'(rxfifo_pop_o), 32'd0);
    chk("off_stray_push", 32'(txfifo_push_o), 32'd0);
    tick();
    dma_ack_i = 1'b0;
    chk("off_stray_ack_r", 32'(dma_ack_r_o), 32'd0);
    chk("off_stray_busy", 32'(busy_o), 32'd0);
    use_dma = 1'b1;
    tick();

    // Last completed burst was RX, so a tie now goes to TX; reset restores RX-first.
    txfifo_count = 5'd0; rxfifo_count = 5'd16;
    dma_req_t_i = 1'b1; dma_req_r_i = 1'b1;
    tick();
    chk("rr_dir_tx", 32'(dma_dir_o), 32'd0);
    ack_words(1, 1'b0);
    #2;
    wb_rst_n_i = 1'b0;
    #1;
    chk("arst_req", 32'(dma_req_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_dir", 32'(dma_dir_o), 32'd0);
    @(posedge clk);
    #1;
    wb_rst_n_i = 1'b1;
    tick();
    chk("arst_rx_first_req", 32'(dma_req_o), 32'd1);
    chk("arst_rx_first_dir", 32'(dma_dir_o), 32'd1);
    dma_req_t_i = 1'b0; dma_req_r_i = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
